// File: rtl/prog_load_ctrl.sv
// Program-load sequencer: streams words into instruction memory, pulses the PC
// reset, then runs the CPU free-running or one debounced step at a time.
module prog_load_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int DEB_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [DATA_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_data,
    output logic              imem_we,
    output logic              pc_rst,
    output logic              cpu_run,
    input  logic              step_mode,
    input  logic              step_btn,
    input  logic              halt_req,
    output logic              busy,
    output logic              err
);

    localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] cnt;
    logic              accept;

    logic              btn_s1, btn_s2;
    logic              deb_level;
    logic [CW-1:0]     deb_cnt;
    logic              step_evt;

    // A pending halt closes the handshake so a halted load never accepts a word.
    assign word_ready = (state == LOAD) && !halt_req;
    assign accept     = word_ready && word_valid;
    assign busy       = (state != IDLE);

    // Synchronise the button, then only change the debounced level after the
    // synchronised value has disagreed with it for DEB_CYC consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            step_evt  <= 1'b0;
        end else begin
            btn_s1   <= step_btn;
            btn_s2   <= btn_s1;
            step_evt <= 1'b0;
            if (btn_s2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CW'(DEB_CYC - 1)) begin
                deb_level <= btn_s2;
                deb_cnt   <= '0;
                step_evt  <= btn_s2;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= '0;
            cnt       <= '0;
            imem_addr <= '0;
            imem_data <= '0;
            imem_we   <= 1'b0;
            pc_rst    <= 1'b0;
            cpu_run   <= 1'b0;
            err       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            pc_rst  <= 1'b0;
            cpu_run <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_req) begin
                        if (load_len == '0) begin
                            err <= 1'b1;
                        end else begin
                            len   <= load_len;
                            cnt   <= '0;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (halt_req) begin
                        state <= IDLE;
                    end else if (accept) begin
                        imem_we   <= 1'b1;
                        imem_addr <= cnt;
                        imem_data <= word_in;
                        cnt       <= cnt + ADDR_W'(1);
                        // The last write and the PC reset land together in FLUSH.
                        if (cnt == len - ADDR_W'(1)) begin
                            state  <= FLUSH;
                            pc_rst <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (halt_req) begin
                        state <= IDLE;
                    end else begin
                        state   <= RUN;
                        cpu_run <= step_mode ? step_evt : 1'b1;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state <= IDLE;
                    end else begin
                        cpu_run <= step_mode ? step_evt : 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: a vector table for the basic load and
// error paths, plus hand-written sequences for bubbles, stepping, halt and reset.
module tb_prog_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic [7:0]  load_len;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        imem_we;
    logic        pc_rst;
    logic        cpu_run;
    logic        step_mode;
    logic        step_btn;
    logic        halt_req;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          pc_cnt;
    logic [7:0]  pc_addr;
    int          run_cnt;

    logic [15:0] words[5] = '{16'h4810, 16'h4A12, 16'h4C14, 16'h4E16, 16'h0880};

    typedef struct {
        logic        load_req;
        logic [7:0]  load_len;
        logic [15:0] word_in;
        logic        word_valid;
        logic        halt_req;
        logic        exp_ready;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
        logic        exp_pc_rst;
        logic        exp_run;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    prog_load_ctrl #(.ADDR_W(8), .DATA_W(16), .DEB_CYC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .load_len   (load_len),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_we    (imem_we),
        .pc_rst     (pc_rst),
        .cpu_run    (cpu_run),
        .step_mode  (step_mode),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // One clock: sample just after the rising edge and log writes/pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_data);
        end
        if (pc_rst) begin
            pc_cnt++;
            pc_addr = imem_we ? imem_addr : 8'hFF;
        end
        if (cpu_run) run_cnt++;
    endtask

    task automatic applyStimulus(input vec_t v);
        load_req   = v.load_req;
        load_len   = v.load_len;
        word_in    = v.word_in;
        word_valid = v.word_valid;
        halt_req   = v.halt_req;
        #1;
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
        pc_cnt  = 0;
        pc_addr = 8'hFF;
        run_cnt = 0;
    endtask

    task automatic idleInputs();
        load_req   = 1'b0;
        load_len   = 8'd0;
        word_in    = 16'h0;
        word_valid = 1'b0;
        halt_req   = 1'b0;
    endtask

    initial begin
        int k;
        int cyc;

        rst_n     = 1'b0;
        step_mode = 1'b0;
        step_btn  = 1'b0;
        idleInputs();
        clearLog();

        //          lr    len    word      val   hlt  | rdy   we    addr   data      pc    run   busy  err
        vecs[0]  = '{1'b1, 8'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'd0, 16'h4810, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 16'h4810, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'd0, 16'h4A12, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 16'h4A12, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'd0, 16'h4C14, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 16'h4C14, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'd0, 16'h4E16, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3, 16'h4E16, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'd0, 16'h0880, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 16'h0880, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 8'd3, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 16'h0880, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 16'h0880, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 16'h0880, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 16'h0880, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 16'h0880, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 16'h0880, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset values while rst_n is held low.
        #12;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ready", {31'd0, word_ready}, 32'd0);
        checkOutput("rst_we", {31'd0, imem_we}, 32'd0);
        checkOutput("rst_run", {31'd0, cpu_run}, 32'd0);
        checkOutput("rst_pc", {31'd0, pc_rst}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_addr", {24'd0, imem_addr}, 32'd0);
        checkOutput("rst_data", {16'd0, imem_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Vector table: full-rate load of 5 words, run, halt, zero-length error.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_ready", i), {31'd0, word_ready}, {31'd0, vecs[i].exp_ready});
            tick();
            checkOutput($sformatf("v%0d_we", i), {31'd0, imem_we}, {31'd0, vecs[i].exp_we});
            checkOutput($sformatf("v%0d_addr", i), {24'd0, imem_addr}, {24'd0, vecs[i].exp_addr});
            checkOutput($sformatf("v%0d_data", i), {16'd0, imem_data}, {16'd0, vecs[i].exp_data});
            checkOutput($sformatf("v%0d_pc", i), {31'd0, pc_rst}, {31'd0, vecs[i].exp_pc_rst});
            checkOutput($sformatf("v%0d_run", i), {31'd0, cpu_run}, {31'd0, vecs[i].exp_run});
            checkOutput($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            checkOutput($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
        end
        idleInputs();

        // Load with a bubble every other cycle.
        clearLog();
        load_req = 1'b1;
        load_len = 8'd5;
        tick();
        load_req = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 5 && cyc < 40) begin
            word_valid = (cyc % 2 == 0);
            word_in    = words[k];
            #1;
            if (word_ready && word_valid) k++;
            tick();
            cyc++;
        end
        checkOutput("bub_accepts", k, 5);
        word_valid = 1'b1;
        word_in    = 16'hDEAD;
        #1;
        checkOutput("bub_flush_ready", {31'd0, word_ready}, 32'd0);
        tick();
        word_valid = 1'b0;
        tick();
        checkOutput("bub_nwrites", wr_addr.size(), 5);
        for (int i = 0; i < 5 && i < wr_addr.size(); i++) begin
            checkOutput($sformatf("bub_addr%0d", i), {24'd0, wr_addr[i]}, i);
            checkOutput($sformatf("bub_data%0d", i), {16'd0, wr_data[i]}, {16'd0, words[i]});
        end
        checkOutput("bub_pc_count", pc_cnt, 1);
        checkOutput("bub_pc_at_last", {24'd0, pc_addr}, 32'd4);
        checkOutput("bub_run", {31'd0, cpu_run}, 32'd1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checkOutput("bub_halt_busy", {31'd0, busy}, 32'd0);

        // Single-step: glitch gives nothing, a held press gives one step.
        step_mode = 1'b1;
        load_req  = 1'b1;
        load_len  = 8'd1;
        tick();
        load_req   = 1'b0;
        word_valid = 1'b1;
        word_in    = 16'h1111;
        tick();
        word_valid = 1'b0;
        tick();
        clearLog();
        step_btn = 1'b1;
        tick();
        tick();
        step_btn = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checkOutput("step_glitch", run_cnt, 0);
        checkOutput("step_busy", {31'd0, busy}, 32'd1);
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        step_btn = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checkOutput("step_press", run_cnt, 1);
        step_mode = 1'b0;
        tick();
        checkOutput("step_to_free", {31'd0, cpu_run}, 32'd1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checkOutput("step_halt_run", {31'd0, cpu_run}, 32'd0);

        // Halt after two accepts, then a fresh 3-word load.
        clearLog();
        load_req = 1'b1;
        load_len = 8'd5;
        tick();
        load_req   = 1'b0;
        word_valid = 1'b1;
        word_in    = 16'hA000;
        tick();
        word_in    = 16'hA001;
        tick();
        halt_req   = 1'b1;
        word_in    = 16'hA002;
        #1;
        checkOutput("halt_ready", {31'd0, word_ready}, 32'd0);
        tick();
        halt_req   = 1'b0;
        word_valid = 1'b0;
        checkOutput("halt_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        checkOutput("halt_nwrites", wr_addr.size(), 2);
        for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
            checkOutput($sformatf("halt_addr%0d", i), {24'd0, wr_addr[i]}, i);
        end
        clearLog();
        load_req = 1'b1;
        load_len = 8'd3;
        tick();
        load_req   = 1'b0;
        word_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word_in = words[i];
            tick();
        end
        word_valid = 1'b0;
        tick();
        tick();
        checkOutput("reload_nwrites", wr_addr.size(), 3);
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            checkOutput($sformatf("reload_addr%0d", i), {24'd0, wr_addr[i]}, i);
            checkOutput($sformatf("reload_data%0d", i), {16'd0, wr_data[i]}, {16'd0, words[i]});
        end
        checkOutput("reload_run", {31'd0, cpu_run}, 32'd1);

        // Asynchronous reset in the middle of RUN.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_run", {31'd0, cpu_run}, 32'd0);
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_we", {31'd0, imem_we}, 32'd0);
        checkOutput("arst_addr", {24'd0, imem_addr}, 32'd0);
        checkOutput("arst_data", {16'd0, imem_data}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_rst_run", {31'd0, cpu_run}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
